// File: rtl/sim_uart_collector_if.sv
// Byte-stream bundle for sim_uart_collector: per-channel input strobes/bytes and the
// single merged output stream with its ready/valid handshake.
interface sim_uart_collector_if #(
  parameter int unsigned NUM_CH = 2
);
  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   in_valid;
  logic [8*NUM_CH-1:0] in_ch;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_ch;
  logic [IDW-1:0]      out_id;
  logic                out_last;

  modport master (
    output in_valid, in_ch, out_ready,
    input  out_valid, out_ch, out_id, out_last
  );

  modport slave (
    input  in_valid, in_ch, out_ready,
    output out_valid, out_ch, out_id, out_last
  );
endinterface

// File: rtl/sim_uart_collector.sv
// Multi-channel UART byte collector: per-channel FIFOs drained whole-line at a time by a
// round-robin arbiter. Define UART_IDLE_FLUSH_EN to also flush lines idle for IDLE_CYCLES.
module sim_uart_collector #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned IDLE_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  sim_uart_collector_if.slave bus,
  output logic [NUM_CH-1:0]   overflow,
  input  logic                clear_overflow
);
  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [7:0]  NL  = 8'h0A;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [IDW-1:0]             grant_q, grant_d;
  logic [IDW-1:0]             rr_q, rr_d;
  logic [CW-1:0]              snap_q, snap_d;
  logic [NUM_CH-1:0]          overflow_q;

  logic [7:0]                 mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [NUM_CH-1:0][CW-1:0]  count_q;
  logic [NUM_CH-1:0][CW-1:0]  nl_cnt_q;

  logic [NUM_CH-1:0]          full, pending, idle_hit;
  logic [NUM_CH-1:0]          push, pop, drop;
  logic [NUM_CH-1:0][7:0]     head, in_byte;
  logic                       found, drain, xfer, last;
  logic [IDW-1:0]             pick;

  always_comb begin
    full    = '0;
    pending = '0;
    head    = '0;
    in_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]    = (count_q[i] == CW'(DEPTH));
      head[i]    = mem[i][rd_ptr_q[i]];
      in_byte[i] = bus.in_ch[8*i +: 8];
      pending[i] = (nl_cnt_q[i] != '0) || full[i] || idle_hit[i];
    end
  end

  assign drain = (state_q == StDrain);
  assign xfer  = drain && bus.out_ready;
  assign last  = drain && ((head[grant_q] == NL) || (snap_q == CW'(1)));

  assign bus.out_valid = drain;
  assign bus.out_ch    = drain ? head[grant_q] : 8'h00;
  assign bus.out_id    = drain ? grant_q : '0;
  assign bus.out_last  = last;
  assign overflow      = overflow_q;

  // A pop in the same cycle frees the slot for that cycle's push.
  always_comb begin
    push = '0;
    pop  = '0;
    drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]  = xfer && (grant_q == IDW'(i));
      push[i] = bus.in_valid[i] && (!full[i] || pop[i]);
      drop[i] = bus.in_valid[i] && full[i] && !pop[i];
    end
  end

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StDrain;
          grant_d = pick;
          snap_d  = count_q[pick];
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          snap_d = snap_q - CW'(1);
          if (last) begin
            state_d = StIdle;
            snap_d  = '0;
            rr_d    = (grant_q == IDW'(NUM_CH - 1)) ? '0 : grant_q + IDW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_q       <= '0;
      snap_q     <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      snap_q     <= snap_d;
      overflow_q <= (overflow_q & ~{NUM_CH{clear_overflow}}) | drop;
    end
  end

  // nl_cnt tracks how many line terminators sit in each FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nl_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        count_q[i]  <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
        nl_cnt_q[i] <= nl_cnt_q[i] + CW'(push[i] && (in_byte[i] == NL))
                                   - CW'(pop[i] && (head[i] == NL));
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr_q[i]] <= in_byte[i];
    end
  end

`ifdef UART_IDLE_FLUSH_EN
  localparam int unsigned TW = $clog2(IDLE_CYCLES + 1);

  logic [NUM_CH-1:0][TW-1:0] idle_q;
  logic [NUM_CH-1:0]         grant_fire;

  always_comb begin
    grant_fire = '0;
    idle_hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_fire[i] = (state_q == StIdle) && found && (pick == IDW'(i));
      idle_hit[i]   = (idle_q[i] == TW'(IDLE_CYCLES));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i] || grant_fire[i]) begin
          idle_q[i] <= '0;
        end else if ((count_q[i] != '0) && !idle_hit[i]) begin
          idle_q[i] <= idle_q[i] + TW'(1);
        end
      end
    end
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^IDLE_CYCLES;
  assign idle_hit        = '0;
`endif

endmodule
